// File: rtl/digital_lock_pkg.sv
// Shared types and width helpers for the serial digital-lock controller.
package digital_lock_pkg;

    typedef enum logic [1:0] {
        S_ENTRY   = 2'd0,
        S_OPEN    = 2'd1,
        S_LOCKOUT = 2'd2
    } state_t;

    localparam int unsigned MODE_SLIDING = 0;
    localparam int unsigned MODE_FRAMED  = 1;

    function automatic int unsigned fail_w(input int unsigned max_fails);
        return $clog2(max_fails + 1);
    endfunction

    function automatic int unsigned bit_w(input int unsigned code_len);
        return $clog2(code_len + 1);
    endfunction

    function automatic int unsigned timer_w(input int unsigned lockout_cycles);
        return $clog2(lockout_cycles + 1);
    endfunction

endpackage

// File: rtl/lock_down_timer.sv
// Loadable down-counter; done flags the final counted cycle (count == 1).
module lock_down_timer #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    input  logic             clear,
    output logic             done
);

    logic [WIDTH-1:0] count;

    // Count register: clear beats load beats decrement; never wraps below zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    // Done flag decoded from the registered count.
    always_comb begin
        done = (count == WIDTH'(1));
    end

endmodule

// File: rtl/digital_lock_seq.sv
// Serial digital-lock controller: sliding or framed code detection with
// failure counting and a timed lockout. Moore outputs only.
module digital_lock_seq
    import digital_lock_pkg::*;
#(
    parameter int unsigned         CODE_LEN       = 4,
    parameter logic [CODE_LEN-1:0] DEFAULT_CODE   = 4'b0110,
    parameter int unsigned         MODE           = 1,
    parameter int unsigned         MAX_FAILS      = 3,
    parameter int unsigned         LOCKOUT_CYCLES = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            bit_in,
    input  logic                            bit_valid,
    input  logic                            code_load,
    input  logic [CODE_LEN-1:0]             code_in,
    input  logic                            relock,
    output logic                            unlocked,
    output logic                            locked_out,
    output logic [fail_w(MAX_FAILS)-1:0]    fail_cnt,
    output logic [bit_w(CODE_LEN)-1:0]      bit_cnt
);

    localparam int unsigned BW = bit_w(CODE_LEN);
    localparam int unsigned FW = fail_w(MAX_FAILS);
    localparam int unsigned TW = timer_w(LOCKOUT_CYCLES);

    state_t              state_q, state_n;
    logic [CODE_LEN-1:0] code_q, code_n;
    logic [CODE_LEN-1:0] shreg_q, shreg_n, shreg_shift;
    logic [BW-1:0]       bit_cnt_n, bit_cnt_sat;
    logic [FW-1:0]       fail_cnt_n;
    logic                tmr_load, tmr_dec, tmr_clear, tmr_done;

    lock_down_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (TW'(LOCKOUT_CYCLES)),
        .dec      (tmr_dec),
        .clear    (tmr_clear),
        .done     (tmr_done)
    );

    // State, code, shift register and counters update together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_ENTRY;
            code_q   <= DEFAULT_CODE;
            shreg_q  <= '0;
            bit_cnt  <= '0;
            fail_cnt <= '0;
        end else begin
            state_q  <= state_n;
            code_q   <= code_n;
            shreg_q  <= shreg_n;
            bit_cnt  <= bit_cnt_n;
            fail_cnt <= fail_cnt_n;
        end
    end

    // Next-state and datapath decisions; comparisons see the incoming bit.
    always_comb begin
        state_n     = state_q;
        code_n      = code_q;
        shreg_n     = shreg_q;
        bit_cnt_n   = bit_cnt;
        fail_cnt_n  = fail_cnt;
        tmr_load    = 1'b0;
        tmr_dec     = 1'b0;
        tmr_clear   = 1'b0;
        shreg_shift = {shreg_q[CODE_LEN-2:0], bit_in};
        bit_cnt_sat = (bit_cnt == BW'(CODE_LEN)) ? bit_cnt : bit_cnt + 1'b1;

        case (state_q)
            S_ENTRY: begin
                if (bit_valid) begin
                    if (MODE == MODE_SLIDING) begin
                        shreg_n   = shreg_shift;
                        bit_cnt_n = bit_cnt_sat;
                        if ((bit_cnt_sat == BW'(CODE_LEN)) && (shreg_shift == code_q))
                            state_n = S_OPEN;
                    end else if (bit_cnt == BW'(CODE_LEN - 1)) begin
                        shreg_n   = '0;
                        bit_cnt_n = '0;
                        if (shreg_shift == code_q) begin
                            state_n    = S_OPEN;
                            fail_cnt_n = '0;
                        end else if ((32'(fail_cnt) + 32'd1) < MAX_FAILS) begin
                            fail_cnt_n = fail_cnt + 1'b1;
                        end else begin
                            fail_cnt_n = FW'(MAX_FAILS);
                            state_n    = S_LOCKOUT;
                            tmr_load   = 1'b1;
                        end
                    end else begin
                        shreg_n   = shreg_shift;
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
            end
            S_OPEN: begin
                if (code_load)
                    code_n = code_in;
                if (relock) begin
                    state_n   = S_ENTRY;
                    shreg_n   = '0;
                    bit_cnt_n = '0;
                end
            end
            S_LOCKOUT: begin
                tmr_dec = 1'b1;
                if (tmr_done) begin
                    state_n    = S_ENTRY;
                    fail_cnt_n = '0;
                    bit_cnt_n  = '0;
                    shreg_n    = '0;
                end
            end
            default: begin
                state_n    = S_ENTRY;
                shreg_n    = '0;
                bit_cnt_n  = '0;
                fail_cnt_n = '0;
                tmr_clear  = 1'b1;
            end
        endcase
    end

    // Moore outputs decoded from the registered state.
    always_comb begin
        unlocked   = (state_q == S_OPEN);
        locked_out = (state_q == S_LOCKOUT);
    end

endmodule

// File: tb/tb_digital_lock_seq.sv
// Scoreboard bench: three lock instances share one stimulus stream; a
// queue-based reference model predicts each instance's outputs per edge.
module tb_digital_lock_seq;

    localparam int unsigned L    = 4;
    localparam int unsigned MAXF = 3;
    localparam int unsigned LOCK = 16;

    logic clk = 1'b0;
    logic reset, bit_in, bit_valid, code_load, relock;
    logic [3:0] code_in;

    logic       ul [3];
    logic       lo [3];
    logic [1:0] fc [3];
    logic [2:0] bc [3];

    always #5 clk = ~clk;

    // Instance 0: framed, code 0110. Instance 1: sliding, 0110. Instance 2: sliding, 0000.
    digital_lock_seq #(.CODE_LEN(4), .DEFAULT_CODE(4'b0110), .MODE(1), .MAX_FAILS(3), .LOCKOUT_CYCLES(16))
    dut_f (.clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid), .code_load(code_load),
           .code_in(code_in), .relock(relock), .unlocked(ul[0]), .locked_out(lo[0]),
           .fail_cnt(fc[0]), .bit_cnt(bc[0]));

    digital_lock_seq #(.CODE_LEN(4), .DEFAULT_CODE(4'b0110), .MODE(0), .MAX_FAILS(3), .LOCKOUT_CYCLES(16))
    dut_s (.clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid), .code_load(code_load),
           .code_in(code_in), .relock(relock), .unlocked(ul[1]), .locked_out(lo[1]),
           .fail_cnt(fc[1]), .bit_cnt(bc[1]));

    digital_lock_seq #(.CODE_LEN(4), .DEFAULT_CODE(4'b0000), .MODE(0), .MAX_FAILS(3), .LOCKOUT_CYCLES(16))
    dut_z (.clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid), .code_load(code_load),
           .code_in(code_in), .relock(relock), .unlocked(ul[2]), .locked_out(lo[2]),
           .fail_cnt(fc[2]), .bit_cnt(bc[2]));

    typedef struct {
        int ul;
        int lo;
        int fc;
        int bc;
    } exp_t;

    exp_t sbq [3][$];

    // Reference model: "open" flag, remaining lockout cycles, failure count,
    // and the bits of the current attempt/window held in a queue.
    bit       m_framed [3] = '{1'b1, 1'b0, 1'b0};
    bit [3:0] m_defc   [3] = '{4'b0110, 4'b0110, 4'b0000};
    bit       m_open   [3];
    int       m_lock   [3];
    int       m_fails  [3];
    bit [3:0] m_code   [3];
    bit       m_hist   [3][$];

    int checks = 0;
    int errors = 0;
    int cyc_no = 0;

    function automatic int hist_val(input int i);
        int v = 0;
        foreach (m_hist[i][k]) v = (v << 1) | int'(m_hist[i][k]);
        return v;
    endfunction

    task automatic model_step(input int i);
        if (!reset) begin
            m_open[i]  = 0;
            m_lock[i]  = 0;
            m_fails[i] = 0;
            m_code[i]  = m_defc[i];
            m_hist[i].delete();
        end else if (m_lock[i] > 0) begin
            m_lock[i]--;
            if (m_lock[i] == 0) begin
                m_fails[i] = 0;
                m_hist[i].delete();
            end
        end else if (m_open[i]) begin
            if (code_load) m_code[i] = code_in;
            if (relock) begin
                m_open[i] = 0;
                m_hist[i].delete();
            end
        end else if (bit_valid) begin
            m_hist[i].push_back(bit_in);
            if (m_framed[i]) begin
                if (m_hist[i].size() == L) begin
                    if (hist_val(i) == int'(m_code[i])) begin
                        m_open[i]  = 1;
                        m_fails[i] = 0;
                    end else begin
                        m_fails[i]++;
                        if (m_fails[i] == MAXF) m_lock[i] = LOCK;
                    end
                    m_hist[i].delete();
                end
            end else begin
                if (m_hist[i].size() > L) void'(m_hist[i].pop_front());
                if (m_hist[i].size() == L && hist_val(i) == int'(m_code[i])) m_open[i] = 1;
            end
        end
    endtask

    // Apply one cycle of inputs at the falling edge and queue the predicted outputs.
    task automatic cyc(input logic r, input logic bv, input logic b,
                       input logic cl, input logic [3:0] ci, input logic rl);
        exp_t e;
        @(negedge clk);
        reset = r; bit_valid = bv; bit_in = b; code_load = cl; code_in = ci; relock = rl;
        for (int i = 0; i < 3; i++) begin
            model_step(i);
            e.ul = int'(m_open[i]);
            e.lo = (m_lock[i] > 0) ? 1 : 0;
            e.fc = m_fails[i];
            e.bc = m_hist[i].size();
            sbq[i].push_back(e);
        end
    endtask

    task automatic send_bit(input logic b);
        cyc(1'b1, 1'b1, b, 1'b0, 4'b0000, 1'b0);
    endtask

    task automatic send_code(input logic [3:0] c);
        for (int k = 3; k >= 0; k--) send_bit(c[k]);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    endtask

    task automatic chk(input string name, input int inst, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s inst%0d cycle %0d: got %0d expected %0d", name, inst, cyc_no, act, exp);
        end
    endtask

    // Monitor: after every rising edge, pop each instance's prediction and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc_no++;
            for (int i = 0; i < 3; i++) begin
                if (sbq[i].size() > 0) begin
                    e = sbq[i].pop_front();
                    chk("unlocked",   i, int'(ul[i]), e.ul);
                    chk("locked_out", i, int'(lo[i]), e.lo);
                    chk("fail_cnt",   i, int'(fc[i]), e.fc);
                    chk("bit_cnt",    i, int'(bc[i]), e.bc);
                end
            end
        end
    end

    initial begin
        reset = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; code_load = 1'b0; code_in = '0; relock = 1'b0;
        do_reset();
        do_reset();

        // Correct framed entry, then relock.
        send_code(4'b0110);
        idle(2);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);

        // Three failures, lockout with ignored bits, then successful entry.
        send_code(4'b1111);
        send_code(4'b1111);
        send_code(4'b1111);
        send_code(4'b0110);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'b1010, 1'b1);
        idle(14);
        send_code(4'b0110);

        // Code change with simultaneous relock.
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'b1010, 1'b1);
        send_code(4'b0110);
        send_code(4'b1010);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);

        // Sliding detection with overlap; all-zero code needs four bits.
        do_reset();
        for (int k = 0; k < 4; k++) send_bit(1'b0);
        do_reset();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);

        // Reset during lockout, then ignored code_load in entry.
        do_reset();
        send_code(4'b1111);
        send_code(4'b1111);
        send_code(4'b1111);
        idle(5);
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'b1111, 1'b0);
        send_code(4'b0110);

        // Long idle gap inside a partial attempt.
        do_reset();
        send_bit(1'b0); send_bit(1'b1);
        idle(100);
        send_bit(1'b1); send_bit(1'b0);

        // Randomised traffic.
        for (int n = 0; n < 2000; n++) begin
            logic r, bv, cl, rl;
            logic [3:0] ci;
            r  = ($urandom_range(0, 299) != 0);
            bv = ($urandom_range(0, 3) != 0);
            cl = ($urandom_range(0, 7) == 0);
            rl = ($urandom_range(0, 5) == 0);
            ci = ($urandom_range(0, 1) == 0) ? 4'b0110 : 4'($urandom_range(0, 15));
            cyc(r, bv, 1'($urandom_range(0, 1)), cl, ci, rl);
        end

        @(posedge clk);
        #3;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (sbq[i].size() != 0) begin
                errors++;
                $display("FAIL drain inst%0d: got %0d pending expected 0", i, sbq[i].size());
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
